// File: rtl/uart_axil_bridge.sv
// uart_axil_bridge: AXI4-Lite slave front end for the UART register file.
// Buffers one AW, one W and one AR beat, then turns each complete request
// into a single-cycle reg_wen/reg_ren strobe and returns the AXI response.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | wait for a complete write pair or a read; arbitrate
// WRITE  | drive reg_addr/reg_wdata, pulse reg_wen unless rejected
// WRESP  | hold bvalid/bresp until bready
// READ   | drive reg_addr, pulse reg_ren unless rejected, capture data
// RRESP  | hold rvalid/rdata/rresp until rready
module uart_axil_bridge #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                  uart_clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [3:0]            s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [3:0]            reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  reg_wen,
  output logic                  reg_ren,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  input  logic                  reg_error
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WRESP,
    S_READ,
    S_RRESP
  } state_t;

  state_t                state_q, state_d;
  logic                  aw_full_q, w_full_q, ar_full_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q, ar_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [3:0]            w_strb_q;
  logic                  last_grant_wr_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q, wdata_q;
  logic                  grant_wr, grant_rd;

  // Addresses widened to 32 bits so the range check and the [5:2] word
  // select work for any bus width, including the default 5-bit bus.
  logic [31:0] aw_addr32, ar_addr32;
  logic        wr_reject, rd_reject;
  logic        aw_hs, w_hs, ar_hs, b_hs, r_hs;

  assign aw_addr32 = 32'(aw_addr_q);
  assign ar_addr32 = 32'(ar_addr_q);
  assign wr_reject = (aw_addr32 >= 32'(4 * NUM_REGS)) || (w_strb_q != 4'hF);
  assign rd_reject = (ar_addr32 >= 32'(4 * NUM_REGS));

  assign s_axil_awready = ~aw_full_q & ~rst;
  assign s_axil_wready  = ~w_full_q & ~rst;
  assign s_axil_arready = ~ar_full_q & ~rst;

  assign aw_hs = s_axil_awvalid & s_axil_awready;
  assign w_hs  = s_axil_wvalid & s_axil_wready;
  assign ar_hs = s_axil_arvalid & s_axil_arready;
  assign b_hs  = (state_q == S_WRESP) & s_axil_bready;
  assign r_hs  = (state_q == S_RRESP) & s_axil_rready;

  assign s_axil_bvalid = (state_q == S_WRESP);
  assign s_axil_rvalid = (state_q == S_RRESP);
  assign s_axil_bresp  = bresp_q;
  assign s_axil_rresp  = rresp_q;
  assign s_axil_rdata  = rdata_q;
  assign reg_wdata     = wdata_q;
  assign reg_addr      = (state_q == S_WRITE) ? aw_addr32[5:2] : ar_addr32[5:2];

  // Holding entries: fill on the address/data handshake, free on the response handshake.
  always_ff @(posedge uart_clk or posedge rst) begin
    if (rst) begin
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      ar_full_q <= 1'b0;
      ar_addr_q <= '0;
    end else begin
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_addr_q <= s_axil_awaddr;
      end else if (b_hs) begin
        aw_full_q <= 1'b0;
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        w_data_q <= s_axil_wdata;
        w_strb_q <= s_axil_wstrb;
      end else if (b_hs) begin
        w_full_q <= 1'b0;
      end
      if (ar_hs) begin
        ar_full_q <= 1'b1;
        ar_addr_q <= s_axil_araddr;
      end else if (r_hs) begin
        ar_full_q <= 1'b0;
      end
    end
  end

  // Next-state, arbitration and register-interface strobes.
  always_comb begin
    state_d  = state_q;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    reg_wen  = 1'b0;
    reg_ren  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (aw_full_q && w_full_q && ar_full_q) begin
          // Contested: alternate, starting with the write after reset.
          grant_rd = last_grant_wr_q;
          grant_wr = ~last_grant_wr_q;
        end else if (aw_full_q && w_full_q) begin
          grant_wr = 1'b1;
        end else if (ar_full_q) begin
          grant_rd = 1'b1;
        end
        if (grant_wr)      state_d = S_WRITE;
        else if (grant_rd) state_d = S_READ;
      end
      S_WRITE: begin
        reg_wen = ~wr_reject;
        state_d = S_WRESP;
      end
      S_WRESP: begin
        if (s_axil_bready) state_d = S_IDLE;
      end
      S_READ: begin
        reg_ren = ~rd_reject;
        state_d = S_RRESP;
      end
      S_RRESP: begin
        if (s_axil_rready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register, grant history, and response/data capture.
  always_ff @(posedge uart_clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      last_grant_wr_q <= 1'b0;
      bresp_q         <= RESP_OKAY;
      rresp_q         <= RESP_OKAY;
      rdata_q         <= '0;
      wdata_q         <= '0;
    end else begin
      state_q <= state_d;
      if (grant_wr) begin
        last_grant_wr_q <= 1'b1;
        wdata_q         <= w_data_q;
      end else if (grant_rd) begin
        last_grant_wr_q <= 1'b0;
      end
      if (state_q == S_WRITE) begin
        bresp_q <= (wr_reject || reg_error) ? RESP_SLVERR : RESP_OKAY;
      end
      if (state_q == S_READ) begin
        rresp_q <= (rd_reject || reg_error) ? RESP_SLVERR : RESP_OKAY;
        rdata_q <= rd_reject ? '0 : reg_rdata;
      end
    end
  end

endmodule

// File: tb/tb_uart_axil_bridge.sv
// Testbench for uart_axil_bridge: table of single transactions plus
// hand-written sequences for latency, ordering, backpressure and reset.
// A 6-bit bus is used so the out-of-range addresses 0x20/0x24 exist.
module tb_uart_axil_bridge;
  localparam int AW = 6;
  localparam int DW = 32;

  logic          uart_clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] s_axil_awaddr = '0;
  logic          s_axil_awvalid = 1'b0;
  logic          s_axil_awready;
  logic [DW-1:0] s_axil_wdata = '0;
  logic [3:0]    s_axil_wstrb = '0;
  logic          s_axil_wvalid = 1'b0;
  logic          s_axil_wready;
  logic [1:0]    s_axil_bresp;
  logic          s_axil_bvalid;
  logic          s_axil_bready = 1'b0;
  logic [AW-1:0] s_axil_araddr = '0;
  logic          s_axil_arvalid = 1'b0;
  logic          s_axil_arready;
  logic [DW-1:0] s_axil_rdata;
  logic [1:0]    s_axil_rresp;
  logic          s_axil_rvalid;
  logic          s_axil_rready = 1'b0;
  logic [3:0]    reg_addr;
  logic [DW-1:0] reg_wdata;
  logic          reg_wen;
  logic          reg_ren;
  logic [DW-1:0] reg_rdata = '0;
  logic          reg_error = 1'b0;

  uart_axil_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(8)) dut (
    .uart_clk(uart_clk), .rst(rst),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
    .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
    .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_wen(reg_wen), .reg_ren(reg_ren), .reg_rdata(reg_rdata),
    .reg_error(reg_error)
  );

  always #5 uart_clk = ~uart_clk;

  int tests = 0;
  int fails = 0;

  // Strobe monitor, sampled mid-cycle.
  int         wen_cnt = 0, ren_cnt = 0, both_cnt = 0;
  logic [3:0] wen_addr = '0, ren_addr = '0;
  logic [31:0] wen_data = '0;
  bit         log_q[$];
  always @(negedge uart_clk) begin
    if (reg_wen) begin
      wen_cnt++;
      wen_addr = reg_addr;
      wen_data = reg_wdata;
      log_q.push_back(1'b1);
    end
    if (reg_ren) begin
      ren_cnt++;
      ren_addr = reg_addr;
      log_q.push_back(1'b0);
    end
    if (reg_wen && reg_ren) both_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge uart_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic wait_b(output logic [1:0] resp);
    bit got = 0;
    int n = 0;
    resp = 2'bxx;
    s_axil_bready = 1'b1;
    while (!got && n < 50) begin
      if (s_axil_bvalid) begin
        resp = s_axil_bresp;
        got = 1;
      end
      tick();
      n++;
    end
    s_axil_bready = 1'b0;
    if (!got) timeout("b_wait");
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    bit ap = 1, wp = 1, ah, wh;
    int n = 0;
    s_axil_awaddr = a;
    s_axil_wdata = d;
    s_axil_wstrb = s;
    s_axil_awvalid = 1'b1;
    s_axil_wvalid = 1'b1;
    while ((ap || wp) && n < 50) begin
      ah = ap && s_axil_awready;
      wh = wp && s_axil_wready;
      tick();
      if (ah) begin ap = 0; s_axil_awvalid = 1'b0; end
      if (wh) begin wp = 0; s_axil_wvalid = 1'b0; end
      n++;
    end
    s_axil_awvalid = 1'b0;
    s_axil_wvalid = 1'b0;
    if (ap || wp) timeout("aw_w_handshake");
    wait_b(resp);
  endtask

  task automatic send_ar(input logic [AW-1:0] a);
    bit done = 0, h;
    int n = 0;
    s_axil_araddr = a;
    s_axil_arvalid = 1'b1;
    while (!done && n < 50) begin
      h = s_axil_arready;
      tick();
      if (h) done = 1;
      n++;
    end
    s_axil_arvalid = 1'b0;
    if (!done) timeout("ar_handshake");
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit got = 0;
    int n = 0;
    d = 'x;
    resp = 2'bxx;
    send_ar(a);
    s_axil_rready = 1'b1;
    while (!got && n < 50) begin
      if (s_axil_rvalid) begin
        d = s_axil_rdata;
        resp = s_axil_rresp;
        got = 1;
      end
      tick();
      n++;
    end
    s_axil_rready = 1'b0;
    if (!got) timeout("r_wait");
  endtask

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] data;      // write data, or reg_rdata source for reads
    logic [3:0]  strb;
    logic        err;
    logic [1:0]  exp_resp;
    int          exp_strobes;
    logic [3:0]  exp_raddr;
    logic [31:0] exp_data;  // reg_wdata for writes, s_axil_rdata for reads
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    int w0, r0, base, bad, n;

    vecs[0] = '{1, 6'h14, 32'h0000_0011, 4'hF, 0, 2'b00, 1, 4'd5, 32'h0000_0011};
    vecs[1] = '{1, 6'h20, 32'h0000_FFFF, 4'hF, 0, 2'b10, 0, 4'd0, 32'h0};
    vecs[2] = '{1, 6'h08, 32'h0000_0077, 4'h1, 0, 2'b10, 0, 4'd0, 32'h0};
    vecs[3] = '{1, 6'h08, 32'h0000_0077, 4'h0, 0, 2'b10, 0, 4'd0, 32'h0};
    vecs[4] = '{0, 6'h24, 32'hDEAD_BEEF, 4'h0, 0, 2'b10, 0, 4'd0, 32'h0};
    vecs[5] = '{0, 6'h1C, 32'h1234_5678, 4'h0, 0, 2'b00, 1, 4'd7, 32'h1234_5678};
    vecs[6] = '{1, 6'h1C, 32'hCAFE_F00D, 4'hF, 1, 2'b10, 1, 4'd7, 32'hCAFE_F00D};
    vecs[7] = '{0, 6'h04, 32'h0000_0055, 4'h0, 1, 2'b10, 1, 4'd1, 32'h0000_0055};
    vecs[8] = '{1, 6'h1F, 32'h0000_A0A0, 4'hF, 0, 2'b00, 1, 4'd7, 32'h0000_A0A0};
    vecs[9] = '{0, 6'h02, 32'h0000_0009, 4'h0, 0, 2'b00, 1, 4'd0, 32'h0000_0009};

    // Reset state.
    tick(); tick();
    check("reset_outputs",
          {s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_bresp, s_axil_arready,
           s_axil_rvalid, s_axil_rresp, s_axil_rdata, reg_addr, reg_wdata, reg_wen, reg_ren}, '0);
    rst = 1'b0;
    #1;
    check("readies_after_reset", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);
    tick();

    // Write latency, AW and W in the same cycle.
    w0 = wen_cnt;
    s_axil_awaddr = 6'h00; s_axil_wdata = 32'h3; s_axil_wstrb = 4'hF;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
    tick();                                   // handshake at end of T0
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    check("lat_t1", {reg_wen, s_axil_bvalid, s_axil_awready, s_axil_wready}, 4'b0000);
    tick();
    check("lat_t2_wen", {reg_wen, reg_addr, reg_wdata}, {1'b1, 4'd0, 32'h3});
    tick();
    check("lat_t3_b", {reg_wen, s_axil_bvalid, s_axil_bresp}, {1'b0, 1'b1, 2'b00});
    s_axil_bready = 1'b1;
    tick();
    s_axil_bready = 1'b0;
    check("lat_wen_once", wen_cnt - w0, 1);
    check("lat_ready_after_b", {s_axil_awready, s_axil_wready, s_axil_bvalid}, 3'b110);

    // Table of single transactions.
    for (int i = 0; i < 10; i++) begin
      w0 = wen_cnt;
      r0 = ren_cnt;
      reg_error = vecs[i].err;
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
        reg_error = 1'b0;
        check($sformatf("v%0d_bresp", i), resp, vecs[i].exp_resp);
        check($sformatf("v%0d_wen_count", i), {wen_cnt - w0, ren_cnt - r0}, {vecs[i].exp_strobes, 32'd0});
        if (vecs[i].exp_strobes != 0)
          check($sformatf("v%0d_wen_payload", i), {wen_addr, wen_data}, {vecs[i].exp_raddr, vecs[i].exp_data});
      end else begin
        reg_rdata = vecs[i].data;
        do_read(vecs[i].addr, rd, resp);
        reg_error = 1'b0;
        check($sformatf("v%0d_rresp", i), resp, vecs[i].exp_resp);
        check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_data);
        check($sformatf("v%0d_ren_count", i), {ren_cnt - r0, wen_cnt - w0}, {vecs[i].exp_strobes, 32'd0});
        if (vecs[i].exp_strobes != 0)
          check($sformatf("v%0d_ren_addr", i), ren_addr, vecs[i].exp_raddr);
      end
    end

    // W five cycles ahead of AW.
    w0 = wen_cnt;
    s_axil_wdata = 32'h1B; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
    tick();
    s_axil_wvalid = 1'b0;
    check("w_early_wready_low", s_axil_wready, 1'b0);
    repeat (4) tick();
    check("w_early_no_wen", {wen_cnt - w0, 31'd0, s_axil_wready}, 64'd0);
    s_axil_awaddr = 6'h10; s_axil_awvalid = 1'b1;
    tick();
    s_axil_awvalid = 1'b0;
    wait_b(resp);
    check("w_early_resp", resp, 2'b00);
    check("w_early_wen", {wen_cnt - w0, wen_addr, wen_data}, {32'd1, 4'd4, 32'h1B});

    // Read with rready held low for 10 cycles.
    r0 = ren_cnt;
    reg_rdata = 32'hA5;
    send_ar(6'h0C);
    n = 0;
    while (!s_axil_rvalid && n < 10) begin tick(); n++; end
    if (!s_axil_rvalid) timeout("rvalid_wait");
    reg_rdata = 32'hFFFF_FFFF;
    bad = 0;
    repeat (10) begin
      if (!s_axil_rvalid || s_axil_rdata !== 32'hA5 || s_axil_rresp !== 2'b00) bad++;
      tick();
    end
    check("r_hold_stable", bad, 0);
    check("r_hold_ren_once", {ren_cnt - r0, ren_addr}, {32'd1, 4'd3});
    check("r_hold_data", s_axil_rdata, 32'hA5);
    s_axil_rready = 1'b1;
    tick();
    s_axil_rready = 1'b0;
    check("r_hold_released", s_axil_rvalid, 1'b0);

    // Simultaneous write/read after reset: write first, then alternation.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    base = log_q.size();
    reg_rdata = 32'h44;
    s_axil_awaddr = 6'h08; s_axil_wdata = 32'h8; s_axil_wstrb = 4'hF; s_axil_araddr = 6'h04;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_arvalid = 1'b1;
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
    s_axil_bready = 1'b1; s_axil_rready = 1'b1;
    repeat (15) tick();
    s_axil_bready = 1'b0; s_axil_rready = 1'b0;
    check("arb1_count", log_q.size() - base, 2);
    if (log_q.size() - base == 2) check("arb1_order", {log_q[base], log_q[base+1]}, 2'b10);
    do_write(6'h0C, 32'h0C, 4'hF, resp);
    check("arb_solo_resp", resp, 2'b00);
    base = log_q.size();
    s_axil_awaddr = 6'h08; s_axil_araddr = 6'h04;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_arvalid = 1'b1;
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
    s_axil_bready = 1'b1; s_axil_rready = 1'b1;
    repeat (15) tick();
    s_axil_bready = 1'b0; s_axil_rready = 1'b0;
    check("arb2_count", log_q.size() - base, 2);
    if (log_q.size() - base == 2) check("arb2_order", {log_q[base], log_q[base+1]}, 2'b01);

    // Reset while a read response is outstanding.
    reg_rdata = 32'h66;
    send_ar(6'h18);
    n = 0;
    while (!s_axil_rvalid && n < 10) begin tick(); n++; end
    check("rst_pre_rvalid", s_axil_rvalid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_drop", {s_axil_rvalid, s_axil_arready, s_axil_rdata}, '0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_arready_back", s_axil_arready, 1'b1);
    tick();
    r0 = ren_cnt;
    reg_rdata = 32'h77;
    do_read(6'h18, rd, resp);
    check("rst_read_after", {rd, resp, ren_cnt - r0}, {32'h77, 2'b00, 32'd1});

    check("no_dual_strobe", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_axil_bridge.md
# uart_axil_bridge

AXI4-Lite slave front end for the UART peripheral. It accepts bus transactions, serializes them into single-cycle `reg_wen`/`reg_ren` strobes on the register-file interface, and returns AXI responses. The block is the initiator of that register interface: it drives `reg_addr`/`reg_wdata` and samples the combinational `reg_rdata` and `reg_error`.

## Interface
- `ADDR_WIDTH`, 5: AXI byte-address width; 0x00–0x1F maps to 8 word registers.
- `DATA_WIDTH`, 32: AXI and register data width; only 32 is supported.
- `NUM_REGS`, 8: words decoded; byte address ≥ 4*NUM_REGS is out of range.
- `uart_clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `s_axil_awaddr`  in  ADDR_WIDTH  write address.
- `s_axil_awvalid`  in  1  write address valid.
- `s_axil_awready`  out  1  write address ready.
- `s_axil_wdata`  in  DATA_WIDTH  write data.
- `s_axil_wstrb`  in  4  byte strobes.
- `s_axil_wvalid`  in  1  write data valid.
- `s_axil_wready`  out  1  write data ready.
- `s_axil_bresp`  out  2  write response: 00 OKAY, 10 SLVERR.
- `s_axil_bvalid`  out  1  write response valid.
- `s_axil_bready`  in  1  write response ready.
- `s_axil_araddr`  in  ADDR_WIDTH  read address.
- `s_axil_arvalid`  in  1  read address valid.
- `s_axil_arready`  out  1  read address ready.
- `s_axil_rdata`  out  DATA_WIDTH  read data.
- `s_axil_rresp`  out  2  read response.
- `s_axil_rvalid`  out  1  read data valid.
- `s_axil_rready`  in  1  read data ready.
- `reg_addr`  out  4  word address (byte address >> 2).
- `reg_wdata`  out  DATA_WIDTH  write data to the register file.
- `reg_wen`  out  1  one-cycle write strobe.
- `reg_ren`  out  1  one-cycle read strobe; it pops RX data, so it must never be issued speculatively.
- `reg_rdata`  in  DATA_WIDTH  combinational read data, valid in the same cycle as `reg_ren`.
- `reg_error`  in  1  access error, sampled in the strobe cycle.

## Operation
- Three independent one-entry holding registers: AW, W, and AR.
  - `awready`, `wready` and `arready` are each high when their entry is empty and `rst` is low.
  - AW and W may arrive in either order or in the same cycle.
- Write entries are freed on the B handshake. The AR entry is freed on the R handshake.
- FSM states:
  - **IDLE**
    - If AW and W are full and AR is empty, go to WRITE.
    - If AR is full and the write pair is not complete, go to READ.
    - If both are ready, grant the opposite of `last_grant`, which resets to READ so a write wins first. Update `last_grant` on each grant.
  - **WRITE**
    - `reg_addr` = `awaddr[5:2]` and `reg_wdata` = W entry.
    - Assert `reg_wen` unless rejected.
    - Register `bresp` and go to WRESP.
  - **WRESP**: `bvalid` = 1 until `bready`; then go to IDLE.
  - **READ**
    - `reg_addr` = `araddr[5:2]`; assert `reg_ren` unless rejected.
    - Capture `rdata` = `reg_rdata`, or 0 if rejected. Register `rresp` and go to RRESP.
  - **RRESP**: `rvalid` = 1 until `rready`; then go to IDLE.
- Reject rules (SLVERR, no strobe issued):
  - address ≥ 4*NUM_REGS;
  - for writes, `wstrb` ≠ 4'hF, including 0.
- `addr[1:0]` is ignored.
- If `reg_error` = 1 in the strobe cycle, the response is SLVERR. The strobe has already been issued.
- At most one register access is in flight; `reg_wen` and `reg_ren` are never high together.
- In states other than WRITE, `reg_addr` follows the AR entry and `reg_wdata` holds its last value. Neither has side effects without a strobe.

## Timing
- Reset (asynchronous, `rst` high):
  - FSM returns to IDLE and all holding entries are cleared.
  - Every output is 0: readies, `bvalid`, `rvalid`, `bresp`, `rresp`, `rdata`, `reg_*`.
  - Any in-flight response is dropped.
  - Readies rise in the first cycle after `rst` falls.
- Write latency: AW+W handshake at cycle T0 → IDLE at T1 → `reg_wen` at T2 → `bvalid` at T3. Earliest next AW/W acceptance is the cycle after the B handshake.
- Read latency: AR handshake at T0 → `reg_ren` at T2 → `rvalid` with data at T3.
- `bvalid`/`rvalid` are held, with stable payload, until their handshake; they do not depend combinationally on `bready`/`rready`.
- If a handshake occurs in the same cycle a new address arrives, the new address waits in its entry. Throughput is one access per 4 cycles with ready masters.
- No AXI input affects any output combinationally.

## Test plan
- Write 0x00000003 to 0x00: AW and W in the same cycle → `reg_wen`=1 for exactly one cycle with `reg_addr`=0, `reg_wdata`=3; then `bresp`=00 at T3.
- W sent 5 cycles before AW to 0x10, data 0x1B → `wready` low after capture; one `reg_wen` with `reg_addr`=4; OKAY.
- Read 0x0C with `reg_rdata` = 0xA5 during `reg_ren`, `rready` held low 10 cycles → exactly one `reg_ren` pulse; `rdata`=0xA5 stable until `rready`.
- Write 0x20, then write 0x08 with `wstrb`=4'h1, then read 0x24 → SLVERR each; no `reg_wen`/`reg_ren` pulse; `rdata`=0.
- Write to 0x08 and read of 0x04 pending in the same IDLE cycle after reset → write strobe first, then read. A second simultaneous pair → read first (alternation).
- Assert `rst` during RRESP with `rvalid`=1 → `rvalid` and `arready` are 0 immediately; after release, a read completes normally with one `reg_ren`.
